// File: rtl/ghr_pkg.sv
// rtl/ghr_pkg.sv - shared history width default and FSM state encoding for the GHR checkpoint controller
package ghr_pkg;
    localparam int GHR_HIST_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_REPAIR  = 2'd2
    } state_t;
endpackage

// File: rtl/ghr_ckpt_ctrl_if.sv
// rtl/ghr_ckpt_ctrl_if.sv - predict/resolve handshakes and sh_reg control bundle
interface ghr_ckpt_ctrl_if #(
    parameter int HIST_W = 14,
    parameter int PTR_W  = 3
);
    logic              pred_valid;
    logic              pred_taken;
    logic              pred_ready;
    logic              res_valid;
    logic              res_mispredict;
    logic              res_taken;
    logic              res_ready;
    logic [HIST_W-1:0] hist_in;
    logic              sr_wr_en;
    logic              sr_wr_data;
    logic              sr_re_en;
    logic [HIST_W-1:0] sr_re_data;
    logic [PTR_W:0]    inflight;

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_mispredict, res_taken, hist_in,
        output pred_ready, res_ready, sr_wr_en, sr_wr_data, sr_re_en, sr_re_data, inflight
    );

    modport master (
        output pred_valid, pred_taken, res_valid, res_mispredict, res_taken, hist_in,
        input  pred_ready, res_ready, sr_wr_en, sr_wr_data, sr_re_en, sr_re_data, inflight
    );
endinterface

// File: rtl/ghr_ckpt_fifo.sv
// rtl/ghr_ckpt_fifo.sv - in-order checkpoint register file with head/tail/count and synchronous flush
module ghr_ckpt_fifo #(
    parameter int HIST_W = 14,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [HIST_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [HIST_W-1:0] head_data_o,
    output logic [PTR_W:0]    count_o
);
    logic [HIST_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q;

    // Storage carries no reset; entries are only read below the count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;
endmodule

// File: rtl/ghr_ckpt_ctrl.sv
// rtl/ghr_ckpt_ctrl.sv - speculative GHR shift/checkpoint/repair sequencer for sh_reg
// Optional GHR_CKPT_STATS_EN adds mispredict_cnt and flush_cnt outputs.
module ghr_ckpt_ctrl
    import ghr_pkg::*;
#(
    parameter int HIST_W = GHR_HIST_W,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    ghr_ckpt_ctrl_if.slave      bus
`ifdef GHR_CKPT_STATS_EN
    ,
    output logic [15:0]         mispredict_cnt,
    output logic [15:0]         flush_cnt
`endif
);
    state_t            state_q;
    logic              taken_q;
    logic [HIST_W-1:0] ckpt_q;

    logic [PTR_W:0]    count;
    logic [HIST_W-1:0] head_data;
    logic              empty, full;
    logic              mis, ok, push, flush;
    logic              pred_ready, res_ready;
    logic              wr_en, wr_data, re_en;
    logic [HIST_W-1:0] re_data;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

    // Reset gates the handshakes so nothing is accepted while sh_reg is also held.
    always_comb begin
        pred_ready = 1'b0;
        res_ready  = 1'b0;
        mis        = 1'b0;
        ok         = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 1'b0;
        re_en      = 1'b0;
        re_data    = '0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    res_ready  = !empty;
                    mis        = bus.res_valid && res_ready && bus.res_mispredict;
                    ok         = bus.res_valid && res_ready && !bus.res_mispredict;
                    pred_ready = !full && !mis;
                    push       = bus.pred_valid && pred_ready;
                    wr_en      = push;
                    wr_data    = push && bus.pred_taken;
                end
                ST_RESTORE: begin
                    re_en   = 1'b1;
                    re_data = ckpt_q;
                end
                ST_REPAIR: begin
                    wr_en   = 1'b1;
                    wr_data = taken_q;
                    flush   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            taken_q <= 1'b0;
            ckpt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mis) begin
                        taken_q <= bus.res_taken;
                        ckpt_q  <= head_data;
                        state_q <= ST_RESTORE;
                    end
                end
                ST_RESTORE: state_q <= ST_REPAIR;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    ghr_ckpt_fifo #(
        .HIST_W (HIST_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (bus.hist_in),
        .pop_i       (ok),
        .flush_i     (flush),
        .head_data_o (head_data),
        .count_o     (count)
    );

`ifdef GHR_CKPT_STATS_EN
    logic [16:0] flush_sum;
    assign flush_sum = {1'b0, flush_cnt} + 17'(count) - 17'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_cnt <= '0;
            flush_cnt      <= '0;
        end else if (mis) begin
            if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
            flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end
`endif

    assign bus.pred_ready = pred_ready;
    assign bus.res_ready  = res_ready;
    assign bus.sr_wr_en   = wr_en;
    assign bus.sr_wr_data = wr_data;
    assign bus.sr_re_en   = re_en;
    assign bus.sr_re_data = re_data;
    assign bus.inflight   = count;
endmodule

// File: doc/ghr_ckpt_ctrl.md
Name: ghr_ckpt_ctrl

Overview:
Sequencing controller for the 14-bit global-history shift register (sh_reg) in the branch predictor.
- Issues a speculative shift for each predicted branch and checkpoints the pre-shift history in an in-order FIFO.
- On a misprediction at the oldest in-flight branch, restores the checkpoint through the register's parallel-load port, shifts in the actual outcome, and flushes all younger checkpoints.
- Sits between the fetch/predict stage, the branch-resolve stage and sh_reg.

Parameters:
HIST_W, 14, history width; must equal the sh_reg width.
DEPTH, 8, number of in-flight branch checkpoints; power of two, at least 2.
PTR_W, 3, log2(DEPTH); width of the head and tail pointers.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
pred_valid  in  1  a predicted branch is presented this cycle.
pred_taken  in  1  predicted direction (1 = taken).
pred_ready  out  1  prediction is accepted this cycle when pred_valid && pred_ready.
res_valid  in  1  the oldest in-flight branch resolves this cycle.
res_mispredict  in  1  resolution disagrees with the prediction.
res_taken  in  1  actual direction.
res_ready  out  1  resolution is accepted this cycle when res_valid && res_ready.
hist_in  in  HIST_W  current sh_reg rd_data.
sr_wr_en  out  1  to sh_reg wr_en.
sr_wr_data  out  1  to sh_reg wr_data.
sr_re_en  out  1  to sh_reg re_en (parallel load).
sr_re_data  out  HIST_W  to sh_reg re_data.
inflight  out  PTR_W+1  number of valid checkpoints.

Behaviour:
- While reset is low:
  - state = IDLE; head, tail and inflight cleared.
  - pred_ready, res_ready and all sr_* outputs forced to 0.
  - Checkpoint RAM contents don't-care.
- FSM states: IDLE, RESTORE, REPAIR.
- sr_* and ready outputs are combinational from state and inputs; everything else is registered.
- Definitions:
  - mis = res_valid && res_ready && res_mispredict.
  - ok = res_valid && res_ready && !res_mispredict.
  - empty = (inflight == 0).
- IDLE:
  - res_ready = !empty.
  - pred_ready = (inflight != DEPTH) && !mis.
  - Accepted prediction:
    - sr_wr_en = 1 and sr_wr_data = pred_taken in the same cycle.
    - At that edge, ckpt[tail] <= hist_in (pre-shift value) and tail++.
    - Back-to-back predictions are legal every cycle.
  - ok: head++ at the edge.
  - Prediction and ok in the same cycle: both take effect; inflight is unchanged.
  - mis: latch res_taken and ckpt[head], then go to RESTORE.
    - No sh_reg write this cycle; the same-cycle prediction is refused.
  - res_valid while empty: ignored (res_ready = 0).
- RESTORE (1 cycle):
  - sr_re_en = 1; sr_re_data = latched checkpoint.
  - pred_ready = 0; res_ready = 0.
  - Next state: REPAIR.
- REPAIR (1 cycle):
  - sr_wr_en = 1; sr_wr_data = latched res_taken.
  - pred_ready = 0; res_ready = 0.
  - At the edge, head, tail and inflight are cleared (all younger branches flushed).
  - Next state: IDLE.
- Misprediction repair latency: the accepted mis cycle plus 2 cycles; pred_ready returns in the 3rd cycle after acceptance.
- Full boundary: pred_ready = 0 when inflight == DEPTH, even if an ok arrives in the same cycle (readiness is based on the registered count).
- Pointers wrap modulo DEPTH.
- inflight is computed as inflight + accepted_pred - ok and saturates at neither end.
- sr_wr_en and sr_re_en are never high in the same cycle.
- Reset asserted mid-RESTORE or mid-REPAIR: immediate return to IDLE with all outputs 0; sh_reg is reset by the same signal.

Optional Feature:
GHR_CKPT_STATS_EN
- Defined:
  - Adds output mispredict_cnt [15:0], counting accepted mis events, saturating at 16'hFFFF.
  - Adds output flush_cnt [15:0], summing the younger checkpoints discarded per flush (inflight - 1), saturating at 16'hFFFF.
  - Both counters are cleared by reset.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Shared package ghr_pkg holds:
  - HIST_W default;
  - state encoding constants ST_IDLE = 2'd0, ST_RESTORE = 2'd1, ST_REPAIR = 2'd2.
- One sub-module: ghr_ckpt_fifo.
  - DEPTH x HIST_W register file with head/tail/count and a flush input.
  - The FSM and output muxing remain in ghr_ckpt_ctrl.

Test Plan:
- Reset with reset = 0, then release:
  - all sr_* = 0 during reset;
  - after release, inflight = 0, pred_ready = 1, res_ready = 0.
- Three predictions taken, not-taken, taken on consecutive cycles, with hist_in 14'h0000, 14'h0001, 14'h0002:
  - sr_wr_en high for 3 cycles with sr_wr_data 1, 0, 1;
  - ckpt[0..2] = 14'h0000, 14'h0001, 14'h0002;
  - inflight = 3.
- Eight predictions:
  - pred_ready = 0 with inflight = 8, and a 9th pred_valid causes no sr_wr_en;
  - one ok resolution gives inflight = 7, then pred_ready = 1.
- Head checkpoint 14'h2cb9 with inflight = 4, then mis with res_taken = 0:
  - next cycle sr_re_en = 1 with sr_re_data = 14'h2cb9;
  - following cycle sr_wr_en = 1 with sr_wr_data = 0;
  - then inflight = 0 and pred_ready = 1;
  - with GHR_CKPT_STATS_EN, flush_cnt = 3 and mispredict_cnt = 1.
- Prediction and ok resolution in the same cycle at inflight = 5:
  - inflight stays 5, sr_wr_en = 1 and head advances.
- Drive reset low during RESTORE:
  - sr_re_en drops to 0 immediately;
  - after release, state is IDLE and inflight = 0.
